// File: rtl/feature_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : feature_stream_loader_pkg
//  Purpose  : Shared types and constants for the feature stream loader:
//             FSM state encoding, feature count, index and class widths.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package feature_stream_loader_pkg;

  localparam int NUM_FEAT = 5;
  localparam int IDX_W    = 3;
  localparam int CLS_W    = 2;
  localparam int CNT_W    = 4;

  // Index value of the last feature byte in a vector.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage : feature_stream_loader_pkg
`default_nettype wire

// File: rtl/feature_stream_loader_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : settle_timer
//  Purpose  : Down-counter timing the classifier settle window.
//  Ports    : clk, rst      - clock, async active-high reset
//             load/load_val - preset the count
//             tick          - decrement by one (saturates at zero)
//             zero          - count has reached zero
//  Revision : 1.0  initial release
// ============================================================================
module settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule : settle_timer
`default_nettype wire

// File: rtl/feature_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : feature_stream_loader
//  Purpose  : Collects five streamed feature bytes into registers X0, X1, X4,
//             X5, X6, waits EVAL_CYCLES for an external classifier to settle,
//             then presents the sampled class on a valid/ready output.
//  Ports    : clk, rst                     - clock, async active-high reset
//             in_valid/in_ready/in_data    - feature byte input handshake
//             X0, X1, X4, X5, X6           - feature vector to classifier
//             cls_in                       - class from the classifier
//             out_valid/out_ready/out_class- result output handshake
//             busy                         - high in SETTLE or RESULT
//  Revision : 1.0  initial release
// ============================================================================
module feature_stream_loader
  import feature_stream_loader_pkg::*;
#(
  parameter int EVAL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [7:0]       X0,
  output logic [7:0]       X1,
  output logic [7:0]       X4,
  output logic [7:0]       X5,
  output logic [7:0]       X6,
  input  logic [CLS_W-1:0] cls_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLS_W-1:0] out_class,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_SETTLE_INIT = CNT_W'(EVAL_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_accept;
  logic             w_timer_load;
  logic             w_timer_tick;
  logic             w_timer_zero;
  logic             w_capture;

  // in_ready is a register, so accept never depends combinationally on
  // anything but in_valid and flops.
  assign w_accept = in_valid && r_in_ready;

  settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_timer_load),
    .load_val (C_SETTLE_INIT),
    .tick     (w_timer_tick),
    .zero     (w_timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_load = 1'b0;
    w_timer_tick = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_accept && (r_idx == LAST_IDX)) begin
          w_state_next = SETTLE;
          w_timer_load = 1'b1;
        end
      end
      SETTLE: begin
        // cls_in is sampled only in the last settle cycle.
        if (w_timer_zero) begin
          w_capture    = 1'b1;
          w_state_next = RESULT;
        end else begin
          w_timer_tick = 1'b1;
        end
      end
      RESULT: begin
        if (r_out_valid && out_ready) begin
          w_state_next = LOAD;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  // Handshake flags are registered from the next state so they track the
  // state register exactly while staying low throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_next == LOAD);
      r_out_valid <= (w_state_next == RESULT);
      r_busy      <= (w_state_next != LOAD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      X0        <= '0;
      X1        <= '0;
      X4        <= '0;
      X5        <= '0;
      X6        <= '0;
      out_class <= '0;
    end else begin
      if (w_accept) begin
        case (r_idx)
          3'd0:    X0 <= in_data;
          3'd1:    X1 <= in_data;
          3'd2:    X4 <= in_data;
          3'd3:    X5 <= in_data;
          default: X6 <= in_data;
        endcase
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (w_capture) begin
        out_class <= cls_in;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule : feature_stream_loader
`default_nettype wire

// File: tb/tb_feature_stream_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_feature_stream_loader
//  Purpose  : Directed self-checking bench for feature_stream_loader.
//             Instance a uses EVAL_CYCLES=2, instance b uses EVAL_CYCLES=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_feature_stream_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [7:0] x0, x1, x4, x5, x6;
  logic [1:0] cls_in = 2'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_class;
  logic       busy;

  logic       in_valid_b = 1'b0;
  logic       in_ready_b;
  logic [7:0] in_data_b = 8'h00;
  logic [7:0] x0_b, x1_b, x4_b, x5_b, x6_b;
  logic [1:0] cls_in_b = 2'd0;
  logic       out_valid_b;
  logic       out_ready_b = 1'b0;
  logic [1:0] out_class_b;
  logic       busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  feature_stream_loader #(.EVAL_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .X0(x0), .X1(x1), .X4(x4), .X5(x5), .X6(x6),
    .cls_in(cls_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .busy(busy)
  );

  feature_stream_loader #(.EVAL_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .X0(x0_b), .X1(x1_b), .X4(x4_b), .X5(x5_b), .X6(x6_b),
    .cls_in(cls_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_class(out_class_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts and ends at a negedge; idles 'gap' cycles, then offers one byte
  // that is accepted on the following posedge.
  task automatic send_a(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    check("send_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid_a(input int max_cycles);
    int n = 0;
    while (!out_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic handshake_a();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int nsent;
    logic prev_valid;

    // ---- reset state -----------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_x0", {24'd0, x0}, 32'd0);
    check("rst_class", {30'd0, out_class}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // ---- back-to-back vector, EVAL=2, cls=3 ------------------------------
    cls_in = 2'd3;
    send_a(8'h10, 0);
    send_a(8'h20, 0);
    send_a(8'h30, 0);
    send_a(8'h40, 0);
    send_a(8'h50, 0);
    // now just after the accepting edge (edge 1 of the latency count)
    check("settle_busy", {31'd0, busy}, 32'd1);
    check("settle_ready", {31'd0, in_ready}, 32'd0);
    check("settle_valid1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("settle_valid2", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_class", {30'd0, out_class}, 32'd3);
    check("v1_x0", {24'd0, x0}, 32'h10);
    check("v1_x1", {24'd0, x1}, 32'h20);
    check("v1_x4", {24'd0, x4}, 32'h30);
    check("v1_x5", {24'd0, x5}, 32'h40);
    check("v1_x6", {24'd0, x6}, 32'h50);

    // ---- RESULT stall with ignored in_valid pulse ------------------------
    cls_in = 2'd0;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 1);
      in_data  = 8'hEE;
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_class", {30'd0, out_class}, 32'd3);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
      check("stall_x0", {24'd0, x0}, 32'h10);
      check("stall_x6", {24'd0, x6}, 32'h50);
    end
    in_valid = 1'b0;
    handshake_a();
    check("hs_valid", {31'd0, out_valid}, 32'd0);
    check("hs_ready", {31'd0, in_ready}, 32'd1);
    check("hs_class_kept", {30'd0, out_class}, 32'd3);
    check("hs_x0_kept", {24'd0, x0}, 32'h10);

    // ---- gapped input -----------------------------------------------------
    cls_in = 2'd1;
    send_a(8'hA1, 2);
    send_a(8'hA2, 2);
    send_a(8'hA3, 2);
    check("gap_x0", {24'd0, x0}, 32'hA1);
    check("gap_x1", {24'd0, x1}, 32'hA2);
    check("gap_x4", {24'd0, x4}, 32'hA3);
    check("gap_x5_old", {24'd0, x5}, 32'h40);
    send_a(8'hA4, 2);
    send_a(8'hA5, 2);
    check("gap_x5", {24'd0, x5}, 32'hA4);
    check("gap_x6", {24'd0, x6}, 32'hA5);
    wait_valid_a(10);
    check("gap_class", {30'd0, out_class}, 32'd1);
    handshake_a();

    // ---- reset mid-vector -------------------------------------------------
    send_a(8'h77, 0);
    send_a(8'h78, 0);
    send_a(8'h79, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_x0", {24'd0, x0}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_class", {30'd0, out_class}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_rdy1", {31'd0, in_ready}, 32'd1);
    cls_in = 2'd2;
    for (int i = 1; i <= 5; i++) send_a(8'(i), 0);
    check("abort_nostale", {31'd0, out_valid}, 32'd0);
    check("new_x0", {24'd0, x0}, 32'h01);
    check("new_x1", {24'd0, x1}, 32'h02);
    check("new_x4", {24'd0, x4}, 32'h03);
    check("new_x5", {24'd0, x5}, 32'h04);
    check("new_x6", {24'd0, x6}, 32'h05);
    wait_valid_a(10);
    check("new_class", {30'd0, out_class}, 32'd2);
    handshake_a();

    // ---- streaming with out_ready tied high ------------------------------
    out_ready  = 1'b1;
    cls_in     = 2'd1;
    pulses     = 0;
    last_pulse = -1;
    nsent      = 0;
    prev_valid = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) begin
        if (prev_valid) check("tp_width", 32'd2, 32'd1);
        if (last_pulse >= 0) check("tp_period", 32'(cyc - last_pulse), 32'd8);
        last_pulse = cyc;
        pulses++;
      end
      prev_valid = out_valid;
      in_valid = (nsent < 15);
      in_data  = 8'(nsent + 1);
      if (in_valid && in_ready) nsent++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("tp_pulses", 32'(pulses), 32'd3);
    check("tp_x6", {24'd0, x6}, 32'd15);
    check("tp_x0", {24'd0, x0}, 32'd11);

    // ---- class toggling in SETTLE, EVAL=3 (instance b) --------------------
    cls_in_b = 2'd1;
    for (int i = 0; i < 5; i++) begin
      in_valid_b = 1'b1;
      in_data_b  = 8'(8'h60 + i);
      @(negedge clk);
    end
    in_valid_b = 1'b0;
    check("b_settle_busy", {31'd0, busy_b}, 32'd1);
    check("b_valid1", {31'd0, out_valid_b}, 32'd0);
    @(negedge clk);
    check("b_valid2", {31'd0, out_valid_b}, 32'd0);
    @(negedge clk);
    check("b_valid3", {31'd0, out_valid_b}, 32'd0);
    cls_in_b = 2'd2;
    @(negedge clk);
    cls_in_b = 2'd0;
    check("b_valid", {31'd0, out_valid_b}, 32'd1);
    check("b_class", {30'd0, out_class_b}, 32'd2);
    check("b_x0", {24'd0, x0_b}, 32'h60);
    check("b_x6", {24'd0, x6_b}, 32'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_feature_stream_loader
`default_nettype wire

// File: doc/feature_stream_loader.md
FEATURE_STREAM_LOADER -- requirements
Module: feature_stream_loader

Interface
REQ-001 SHALL have parameter EVAL_CYCLES, default 2, giving the classifier settle cycles waited before the class is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  feature byte offered.
REQ-005 SHALL have port in_ready  output  1  loader accepts feature byte.
REQ-006 SHALL have port in_data  input  8  feature byte.
REQ-007 SHALL have ports X0, X1, X4, X5, X6  output  8 each  registered feature vector driven to the classifier.
REQ-008 SHALL have port cls_in  input  2  combinational class returned by the classifier.
REQ-009 SHALL have port out_valid  output  1  class result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port out_class  output  2  registered class result.
REQ-012 SHALL have port busy  output  1  high in SETTLE or RESULT.

Function
REQ-013 SHALL implement FSM states LOAD, SETTLE, RESULT.
REQ-014 LOAD: in_ready=1; a byte is accepted only when in_valid&&in_ready at a clock edge.
REQ-015 Accepted bytes SHALL fill features in fixed order X0, X1, X4, X5, X6; 3-bit index 0..4; unaccepted cycles leave registers and index unchanged.
REQ-016 Accepting the 5th byte (index 4) SHALL move to SETTLE, load the settle counter with EVAL_CYCLES-1, and reset the index to 0.
REQ-017 SETTLE: in_ready=0, features held stable; counter decrements each cycle; when the counter is 0, cls_in SHALL be captured into out_class and the state SHALL move to RESULT.
REQ-018 Latency: out_valid rises exactly EVAL_CYCLES+1 edges after the edge accepting the 5th byte; only cls_in in the final SETTLE cycle matters.
REQ-019 RESULT: out_valid=1, in_ready=0; out_class and features held stable until out_valid&&out_ready.
REQ-020 On the RESULT handshake, the FSM SHALL return to LOAD; out_valid drops next cycle; out_class and features keep their values until overwritten.
REQ-021 in_valid during SETTLE/RESULT SHALL be ignored, with no data loss since in_ready=0.
REQ-022 in_ready, out_valid, and busy SHALL be decoded from registered state only, with no combinational path from in_valid/out_ready.
REQ-023 Sustained throughput: one result per 5+EVAL_CYCLES+1 cycles with no stalls.

Reset
REQ-024 While rst=1: state=LOAD, index=0, counter=0, X0..X6=0, out_class=0, out_valid=0, busy=0, in_ready forced 0.
REQ-025 rst asserted mid-LOAD, SETTLE, or RESULT SHALL abort the vector; partial bytes are discarded and no result is emitted.
REQ-026 in_ready SHALL go to 1 on the first edge after rst deasserts.

Structure
REQ-027 The shared package SHALL hold the state enum, NUM_FEAT=5, the feature-index width (3), and the class width (2).
REQ-028 The settle down-counter SHALL be the one sub-module, settle_timer (load, tick, zero flag).
REQ-029 The block SHALL contain no classifier logic; cls_in is connected externally to the tree module outputs.

Verification
REQ-030 Send bytes 0x10,0x20,0x30,0x40,0x50 back-to-back with EVAL_CYCLES=2 and cls_in=3 -> X0=0x10, X1=0x20, X4=0x30, X5=0x40, X6=0x50; out_valid rises 3 edges after the 5th byte with out_class=3.
REQ-031 Hold out_ready=0 for 4 cycles in RESULT -> out_valid, out_class, and X* stable; in_ready=0; an in_valid pulse is ignored.
REQ-032 Insert in_valid gaps of 2 idle cycles between bytes 0xA1..0xA5 -> same order mapping, and the index advances only on handshakes.
REQ-033 Assert rst after 3 accepted bytes, then send 5 new bytes 0x01..0x05 -> X0=0x01, X6=0x05, and no stale result.
REQ-034 Toggle cls_in 1->2 in SETTLE with EVAL_CYCLES=3, where cls_in=2 in the final settle cycle -> out_class=2.
REQ-035 Run 3 vectors with out_ready tied 1 -> out_valid pulses 1 cycle each, at a 5+EVAL_CYCLES+1 cycle period.
